// File: rtl/hack_alu.sv
// Hack-style 16-bit ALU: operand preset (zero/invert), add or AND, optional
// output inversion, with the result and its zero/negative flags registered.
module hack_alu #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic                     zx,
  input  logic                     nx,
  input  logic                     zy,
  input  logic                     ny,
  input  logic                     f,
  input  logic                     no,
  output logic signed [DATA_W-1:0] out,
  output logic                     zr,
  output logic                     ng
);

  // Zeroing is applied before inversion, so zero+invert yields all ones.
  function automatic logic signed [DATA_W-1:0] preset(
    input logic signed [DATA_W-1:0] v,
    input logic                     zero,
    input logic                     inv
  );
    logic signed [DATA_W-1:0] t;
    t = zero ? '0 : v;
    return inv ? ~t : t;
  endfunction

  function automatic logic signed [DATA_W-1:0] compute(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     sel_add,
    input logic                     inv_out
  );
    logic signed [DATA_W-1:0] r;
    r = sel_add ? (a + b) : (a & b);
    return inv_out ? ~r : r;
  endfunction

  logic signed [DATA_W-1:0] xx_p0;
  logic signed [DATA_W-1:0] yy_p0;
  logic signed [DATA_W-1:0] res_p0;

  logic signed [DATA_W-1:0] out_p1_d, out_p1_q;
  logic                     zr_p1_d,  zr_p1_q;
  logic                     ng_p1_d,  ng_p1_q;

  // Stage p0: combinational preset and function, flags taken from the final result
  always_comb begin
    xx_p0  = preset(x, zx, nx);
    yy_p0  = preset(y, zy, ny);
    res_p0 = compute(xx_p0, yy_p0, f, no);
    if (reset) begin
      out_p1_d = '0;
      zr_p1_d  = 1'b1;
      ng_p1_d  = 1'b0;
    end else begin
      out_p1_d = res_p0;
      zr_p1_d  = (res_p0 == '0);
      ng_p1_d  = res_p0[DATA_W-1];
    end
  end

  // Stage p1: output registers
  always_ff @(posedge clk) begin
    out_p1_q <= out_p1_d;
    zr_p1_q  <= zr_p1_d;
    ng_p1_q  <= ng_p1_d;
  end

  assign out = out_p1_q;
  assign zr  = zr_p1_q;
  assign ng  = ng_p1_q;

endmodule

// File: tb/tb_hack_alu.sv
// Scoreboard bench for hack_alu: stimulus pushes expected results, a monitor
// pops and compares one cycle after each applied operation.
module tb_hack_alu;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] x, y;
  logic               zx, nx, zy, ny, f, no;
  logic signed [15:0] out;
  logic               zr, ng;

  hack_alu #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out), .zr(zr), .ng(ng)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic        z;
    logic        n;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // The 18 standard control words, in table order
  logic [5:0] std_ctrl [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
  };

  // Semantic meaning of each standard row, independent of the control bits
  function automatic logic [15:0] std_model(input int idx, input logic [15:0] a, input logic [15:0] b);
    int ia = int'(a);
    int ib = int'(b);
    case (idx)
      0:  return 16'(0);
      1:  return 16'(1);
      2:  return 16'(-1);
      3:  return a;
      4:  return b;
      5:  return ~a;
      6:  return ~b;
      7:  return 16'(-ia);
      8:  return 16'(-ib);
      9:  return 16'(ia + 1);
      10: return 16'(ib + 1);
      11: return 16'(ia - 1);
      12: return 16'(ib - 1);
      13: return 16'(ia + ib);
      14: return 16'(ia - ib);
      15: return 16'(ib - ia);
      16: return a & b;
      default: return a | b;
    endcase
  endfunction

  // General rule model for arbitrary control words
  function automatic logic [15:0] rule_model(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] xa, yb, r;
    xa = c[5] ? 16'h0000 : a;
    if (c[4]) xa = ~xa;
    yb = c[3] ? 16'h0000 : b;
    if (c[2]) yb = ~yb;
    r = c[1] ? 16'((int'(xa) + int'(yb)) % 65536) : (xa & yb);
    return c[0] ? ~r : r;
  endfunction

  task automatic apply(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c,
                       input logic rst, input logic [15:0] exp_out, input string name);
    exp_t e;
    @(negedge clk);
    x = xv; y = yv; reset = rst;
    {zx, nx, zy, ny, f, no} = c;
    e.o = rst ? 16'h0000 : exp_out;
    e.z = (e.o == 16'h0000);
    e.n = e.o[15];
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: each applied operation shows up right after the following edge
  exp_t m;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      checks++;
      if (out !== m.o || zr !== m.z || ng !== m.n) begin
        errors++;
        $display("FAIL %s: got out=%h zr=%b ng=%b, expected out=%h zr=%b ng=%b",
                 m.name, out, zr, ng, m.o, m.z, m.n);
      end
    end
  end

  initial begin
    logic [15:0] rx, ry;
    logic [5:0]  rc;
    reset = 1'b1; x = '0; y = '0;
    {zx, nx, zy, ny, f, no} = 6'b000000;

    // Reset held for several edges with non-zero operands present
    apply(16'h1234, 16'h5678, 6'b000010, 1'b1, 16'h0, "reset_hold0");
    apply(16'hFFFF, 16'h8000, 6'b111111, 1'b1, 16'h0, "reset_hold1");
    apply(16'h1234, 16'h5678, 6'b000010, 1'b1, 16'h0, "reset_hold2");

    apply(16'h1234, 16'hABCD, 6'b111111, 1'b0, 16'h0001, "const_one");
    apply(16'h1234, 16'hABCD, 6'b111010, 1'b0, 16'hFFFF, "const_minus1");
    apply(16'h1234, 16'hABCD, 6'b101010, 1'b0, 16'h0000, "const_zero");
    apply(16'h0005, 16'h0003, 6'b010011, 1'b0, 16'h0002, "x_minus_y");
    apply(16'h0005, 16'h0003, 6'b000111, 1'b0, 16'hFFFE, "y_minus_x");
    apply(16'h8000, 16'h8000, 6'b000010, 1'b0, 16'h0000, "wrap_add");
    apply(16'h7FFF, 16'h0001, 6'b000010, 1'b0, 16'h8000, "ovf_add");
    apply(16'h00F0, 16'h0F00, 6'b010101, 1'b0, 16'h0FF0, "x_or_y");
    apply(16'h00F0, 16'h0F00, 6'b000000, 1'b0, 16'h0000, "x_and_y");
    apply(16'h8000, 16'h0000, 6'b001111, 1'b0, 16'h8000, "neg_min");

    // Reset mid-stream discards the pending result
    apply(16'h0003, 16'h0004, 6'b000010, 1'b0, 16'h0007, "pre_reset_add");
    apply(16'h0003, 16'h0004, 6'b000010, 1'b1, 16'h0000, "mid_reset");
    apply(16'h0005, 16'h0009, 6'b000010, 1'b0, 16'h000E, "post_reset_add");

    // Random operands across all 18 standard rows
    for (int p = 0; p < 110; p++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (p == 0) begin rx = 16'h0000; ry = 16'hFFFF; end
      if (p == 1) begin rx = 16'h8000; ry = 16'h7FFF; end
      for (int r = 0; r < 18; r++)
        apply(rx, ry, std_ctrl[r], 1'b0, std_model(r, rx, ry), $sformatf("std_row%0d", r));
    end

    // Arbitrary control words including the non-standard ones, with occasional reset
    for (int k = 0; k < 300; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom_range(0, 63));
      apply(rx, ry, rc, ($urandom_range(0, 19) == 0), rule_model(rc, rx, ry),
            $sformatf("ctrl_%b", rc));
    end

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
